// File: rtl/led_sft_arb_if.sv
// Requester-side and shift-chain signals of the shared LED shift-chain arbiter.
// The master modport is the requester/bench side, the slave modport is the arbiter.
interface led_sft_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               sft_shcp;
  logic               sft_ds;
  logic               sft_stcp;

  modport master (
    output req, din,
    input  gnt, done, busy, sft_shcp, sft_ds, sft_stcp
  );

  modport slave (
    input  req, din,
    output gnt, done, busy, sft_shcp, sft_ds, sft_stcp
  );
endinterface

// File: rtl/led_sft_arb.sv
// Round-robin arbiter sharing one 74HC595-style LED shift chain between NREQ requesters.
// Each granted word is shifted out MSB-first, then committed with one storage-latch pulse.
module led_sft_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned DIV  = 4
) (
  input logic         clk,
  input logic         rst_n,
  led_sft_arb_if.slave bus
);
  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW  = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned LastW = $clog2(NREQ);

  localparam logic [DivW-1:0]  DivMax  = DivW'(DIV - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(DW - 1);
  localparam logic [LastW-1:0] LastRst = LastW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e           state_q;
  logic [DivW-1:0]  div_q;
  logic [BitW-1:0]  bit_q;
  logic [LastW-1:0] last_q;
  logic [DW-1:0]    sreg_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic             shcp_q;
  logic             ds_q;
  logic             stcp_q;

  logic             found;
  logic [LastW-1:0] win;
  logic [LastW-1:0] idx;
  logic [DW-1:0]    win_word;
  logic [DW-1:0]    sreg_shl;

  // Search upward from the slot after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = LastW'((32'(last_q) + off) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_word = bus.din[32'(win)*DW +: DW];
  end

  assign sreg_shl = sreg_q << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      last_q  <= LastRst;
      sreg_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      shcp_q  <= 1'b0;
      ds_q    <= 1'b0;
      stcp_q  <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        StIdle: begin
          if (found) begin
            sreg_q  <= win_word;
            gnt_q   <= NREQ'(1) << win;
            last_q  <= win;
            ds_q    <= win_word[DW-1];
            div_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (div_q != DivMax) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!shcp_q) begin
              shcp_q <= 1'b1;
            end else begin
              // Data only moves on the falling shift clock to keep setup/hold symmetric.
              shcp_q <= 1'b0;
              sreg_q <= sreg_shl;
              if (bit_q == BitMax) begin
                ds_q    <= 1'b0;
                stcp_q  <= 1'b1;
                state_q <= StLatch;
              end else begin
                ds_q  <= sreg_shl[DW-1];
                bit_q <= bit_q + 1'b1;
              end
            end
          end
        end
        StLatch: begin
          if (div_q != DivMax) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q   <= '0;
            stcp_q  <= 1'b0;
            done_q  <= NREQ'(1) << last_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.sft_shcp = shcp_q;
  assign bus.sft_ds   = ds_q;
  assign bus.sft_stcp = stcp_q;
endmodule
